// File: rtl/rand_range_sampler_if.sv
// Sample-stream bundle: RNG word input plus the valid/ready sample output.
// The slave modport is the sampler's view; master is the producer/consumer side.
interface rand_range_sampler_if #(
  parameter int WIDTH = 8
) ();
  logic [31:0]      RAND_IN;
  logic             RAND_VALID;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;

  modport slave (
    input  RAND_IN, RAND_VALID, OUT_READY,
    output OUT_DATA, OUT_VALID
  );

  modport master (
    output RAND_IN, RAND_VALID, OUT_READY,
    input  OUT_DATA, OUT_VALID
  );
endinterface

// File: rtl/rand_range_sampler.sv
// Rejection-samples the low WIDTH bits of an RNG word into [0, RANGE-1], after discarding
// PRIME_DISCARD words post-reset; accepted samples queue in a FIFO, dropping (and counting) on overflow.
module rand_range_sampler #(
  parameter int WIDTH         = 8,
  parameter int RANGE         = 200,
  parameter int FIFO_DEPTH    = 4,
  parameter int PRIME_DISCARD = 3
) (
  input  logic                          CLK,
  input  logic                          RESET,
  rand_range_sampler_if.slave           bus,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          PRIMED,
  output logic [15:0]                   DROP_CNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [7:0]    PD_L     = 8'(PRIME_DISCARD);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  // Reset asserts asynchronously everywhere; release is retimed to CLK.
  logic rst_meta_q, rst_sync_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic rst_n;
  assign rst_n = rst_sync_q;

  state_t     state_q;
  logic [7:0] prime_cnt_q;
  logic       primed_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prime_cnt_q <= 8'd0;
      primed_q    <= 1'b0;
    end else if (bus.RAND_VALID) begin
      case (state_q)
        IDLE: begin
          prime_cnt_q <= 8'd1;
          if (PRIME_DISCARD <= 1) begin
            state_q  <= RUN;
            primed_q <= 1'b1;
          end else begin
            state_q <= PRIME;
          end
        end
        PRIME: begin
          prime_cnt_q <= prime_cnt_q + 8'd1;
          if (prime_cnt_q + 8'd1 == PD_L) begin
            state_q  <= RUN;
            primed_q <= 1'b1;
          end
        end
        RUN:     state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

  // With no priming, the very first valid word is already a sample.
  logic             sample_en;
  logic [WIDTH-1:0] cand;
  logic             sample_vld;
  logic             unused_rand_bits;

  assign sample_en        = (state_q == RUN) || ((PRIME_DISCARD == 0) && (state_q == IDLE));
  assign cand             = bus.RAND_IN[WIDTH-1:0];
  assign sample_vld       = sample_en && bus.RAND_VALID && (32'(cand) < 32'(RANGE));
  assign unused_rand_bits = ^bus.RAND_IN[31:WIDTH];

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic [15:0]      drop_q;
  logic             full, pop, do_push, drop;

  always_comb begin
    full    = (level_q == LVL_FULL);
    pop     = (level_q != '0) && bus.OUT_READY;
    do_push = sample_vld && (!full || pop);
    drop    = sample_vld && full && !pop;
    level_d = level_q;
    case ({do_push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 16'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= cand;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.OUT_DATA  = mem_q[rd_ptr_q];
  assign bus.OUT_VALID = (level_q != '0);
  assign LEVEL         = level_q;
  assign PRIMED        = primed_q;
  assign DROP_CNT      = drop_q;

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed bench: two samplers (3-word and 2-word priming) on a shared clock and reset.
module tb_rand_range_sampler;

  logic        CLK;
  logic        RESET;
  logic [2:0]  LEVEL, LEVEL2;
  logic        PRIMED, PRIMED2;
  logic [15:0] DROP_CNT, DROP_CNT2;

  int n_cmp = 0;
  int n_err = 0;

  rand_range_sampler_if #(.WIDTH(8)) if0 ();
  rand_range_sampler_if #(.WIDTH(8)) if1 ();

  rand_range_sampler #(.WIDTH(8), .RANGE(200), .FIFO_DEPTH(4), .PRIME_DISCARD(3)) u_dut (
    .CLK(CLK), .RESET(RESET), .bus(if0.slave),
    .LEVEL(LEVEL), .PRIMED(PRIMED), .DROP_CNT(DROP_CNT)
  );

  rand_range_sampler #(.WIDTH(8), .RANGE(200), .FIFO_DEPTH(4), .PRIME_DISCARD(2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .bus(if1.slave),
    .LEVEL(LEVEL2), .PRIMED(PRIMED2), .DROP_CNT(DROP_CNT2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input logic vld, input logic [31:0] word);
    if0.RAND_VALID = vld;
    if0.RAND_IN    = word;
    cycle();
    if0.RAND_VALID = 1'b0;
  endtask

  initial begin
    RESET = 1'b0;
    if0.RAND_IN = '0; if0.RAND_VALID = 1'b0; if0.OUT_READY = 1'b0;
    if1.RAND_IN = '0; if1.RAND_VALID = 1'b0; if1.OUT_READY = 1'b0;
    #3;
    check("rst_out_valid", 32'(if0.OUT_VALID), 0);
    check("rst_out_data",  32'(if0.OUT_DATA), 0);
    check("rst_level",     32'(LEVEL), 0);
    check("rst_primed",    32'(PRIMED), 0);
    check("rst_drop_cnt",  32'(DROP_CNT), 0);
    repeat (2) cycle();
    RESET = 1'b1;
    repeat (3) cycle();

    // T5: gapped valids while priming a 2-discard instance
    if1.RAND_IN = 32'h5;
    if1.RAND_VALID = 1'b1; cycle();
    check("t5_cyc1_primed", 32'(PRIMED2), 0);
    if1.RAND_VALID = 1'b0; cycle();
    check("t5_cyc2_primed", 32'(PRIMED2), 0);
    cycle();
    check("t5_cyc3_primed", 32'(PRIMED2), 0);
    if1.RAND_VALID = 1'b1; cycle();
    check("t5_cyc4_primed", 32'(PRIMED2), 1);
    check("t5_level",       32'(LEVEL2), 0);
    if1.RAND_VALID = 1'b0;

    // T1: three words discarded, fourth sampled
    if0.OUT_READY = 1'b1;
    step(1'b1, 32'h5);
    step(1'b1, 32'h5);
    check("t1_primed_w2", 32'(PRIMED), 0);
    step(1'b1, 32'h5);
    check("t1_primed_w3", 32'(PRIMED), 1);
    check("t1_level_w3",  32'(LEVEL), 0);
    step(1'b1, 32'h5);
    check("t1_valid_w4",  32'(if0.OUT_VALID), 1);
    check("t1_data_w4",   32'(if0.OUT_DATA), 5);
    step(1'b0, 32'h0);
    check("t1_level_pop", 32'(LEVEL), 0);

    // T2: acceptance boundaries
    if0.OUT_READY = 1'b0;
    step(1'b1, 32'h000000C7);
    check("t2_data_199",   32'(if0.OUT_DATA), 199);
    check("t2_level_199",  32'(LEVEL), 1);
    step(1'b1, 32'h000000C8);
    check("t2_level_200",  32'(LEVEL), 1);
    step(1'b1, 32'hFFFFFFFF);
    check("t2_level_ff",   32'(LEVEL), 1);
    check("t2_drop",       32'(DROP_CNT), 0);
    if0.OUT_READY = 1'b1;
    step(1'b0, 32'h0);
    if0.OUT_READY = 1'b0;
    step(1'b1, 32'h12345600);
    check("t2_data_0",     32'(if0.OUT_DATA), 0);
    check("t2_level_0",    32'(LEVEL), 1);
    if0.OUT_READY = 1'b1;
    step(1'b0, 32'h0);
    check("t2_level_empty", 32'(LEVEL), 0);

    // T3: overflow with consumer stalled
    if0.OUT_READY = 1'b0;
    for (int i = 10; i <= 15; i++) step(1'b1, 32'(i));
    check("t3_level", 32'(LEVEL), 4);
    check("t3_drop",  32'(DROP_CNT), 2);
    if0.OUT_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_drain%0d", k), 32'(if0.OUT_DATA), 32'(10 + k));
      step(1'b0, 32'h0);
    end
    check("t3_level_drained", 32'(LEVEL), 0);
    check("t3_valid_drained", 32'(if0.OUT_VALID), 0);

    // T4: push and pop together while full
    if0.OUT_READY = 1'b0;
    for (int i = 20; i <= 23; i++) step(1'b1, 32'(i));
    check("t4_level_full", 32'(LEVEL), 4);
    if0.OUT_READY = 1'b1;
    step(1'b1, 32'd7);
    check("t4_level_pp",   32'(LEVEL), 4);
    check("t4_drop_pp",    32'(DROP_CNT), 2);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t4_drain%0d", k), 32'(if0.OUT_DATA), (k < 3) ? 32'(21 + k) : 32'd7);
      step(1'b0, 32'h0);
    end
    check("t4_level_drained", 32'(LEVEL), 0);

    // T6: asynchronous reset between edges
    if0.OUT_READY = 1'b0;
    step(1'b1, 32'd1);
    step(1'b1, 32'd2);
    step(1'b1, 32'd3);
    check("t6_level_pre", 32'(LEVEL), 3);
    #2;
    RESET = 1'b0;
    #1;
    check("t6_valid",   32'(if0.OUT_VALID), 0);
    check("t6_level",   32'(LEVEL), 0);
    check("t6_primed",  32'(PRIMED), 0);
    check("t6_drop",    32'(DROP_CNT), 0);
    check("t6_primed2", 32'(PRIMED2), 0);
    repeat (2) cycle();
    RESET = 1'b1;
    repeat (3) cycle();
    if0.OUT_READY = 1'b1;
    step(1'b1, 32'd5);
    step(1'b1, 32'd5);
    check("t6_reprime_w2", 32'(PRIMED), 0);
    step(1'b1, 32'd5);
    check("t6_reprime_w3", 32'(PRIMED), 1);
    check("t6_level_w3",   32'(LEVEL), 0);
    step(1'b1, 32'd9);
    check("t6_data_w4",    32'(if0.OUT_DATA), 9);
    check("t6_valid_w4",   32'(if0.OUT_VALID), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
